// File: rtl/piso_tx_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
//   state_t    : frame controller states
//   len_width  : width of the LEN field for a given holding-register width
//   clamp_len  : maps a requested length onto 1..data_w (0 or oversize -> data_w)
package piso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHIFT  = 2'd2
  } state_t;

  function automatic int unsigned len_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned data_w);
    return (len == 0 || len > data_w) ? data_w : len;
  endfunction

endpackage

// File: rtl/piso_serial_tx_if.sv
// Host/line bundle of the serial transmitter.
//   master : host side (drives data, length, divider and control strobes)
//   slave  : transmitter side (drives ready/busy/done and the serial line)
interface piso_serial_tx_if
  import piso_tx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 16
);
  localparam int LEN_W = len_width(DATA_W);

  logic [DATA_W-1:0] DIN;
  logic [LEN_W-1:0]  LEN;
  logic              LOAD_VALID;
  logic              LOAD_READY;
  logic              START_TX;
  logic [DIV_W-1:0]  DIV;
  logic              ABORT;
  logic              SOUT;
  logic              SCLK;
  logic              TX_BUSY;
  logic              TX_DONE;

  modport master (
    output DIN, LEN, LOAD_VALID, START_TX, DIV, ABORT,
    input  LOAD_READY, SOUT, SCLK, TX_BUSY, TX_DONE
  );

  modport slave (
    input  DIN, LEN, LOAD_VALID, START_TX, DIV, ABORT,
    output LOAD_READY, SOUT, SCLK, TX_BUSY, TX_DONE
  );
endinterface

// File: rtl/piso_bit_timer.sv
// Bit-period timer. Latches the divider on start and counts 0..div each bit.
//   CLK, RESET  : clock, async active-high reset
//   start       : latch div_in and restart the count
//   run         : count while high, held at zero otherwise
//   div_in      : bit period minus one
//   bit_end     : high on the final cycle of a bit period
//   sclk_phase  : high for the second half of the bit period
module piso_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             run,
  input  logic [DIV_W-1:0] div_in,
  output logic             bit_end,
  output logic             sclk_phase
);
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W:0]   div_p1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q   <= '0;
      div_cnt <= '0;
    end else if (start) begin
      div_q   <= div_in;
      div_cnt <= '0;
    end else if (run) begin
      if (bit_end) div_cnt <= '0;
      else         div_cnt <= div_cnt + DIV_W'(1);
    end else begin
      div_cnt <= '0;
    end
  end

  assign bit_end = run && (div_cnt == div_q);

  // One extra bit so div = all-ones does not overflow; (div+1)>>1 is the upper slice.
  assign div_p1     = {1'b0, div_q} + (DIV_W+1)'(1);
  assign sclk_phase = (div_cnt >= div_p1[DIV_W:1]);
endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter, single clock domain.
//   CLK, RESET : clock, async active-high reset
//   bus        : slave side of piso_serial_tx_if (load, start, divider, abort,
//                serial data/clock, busy, done)
// A word is loaded (IDLE/LOADED), then shifted out one bit per DIV+1 cycles.
// The word is consumed by the frame; TX_DONE pulses one cycle after the last bit.
module piso_serial_tx
  import piso_tx_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DIV_W     = 16,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  piso_serial_tx_if.slave   bus
);
  localparam int LEN_W = len_width(DATA_W);

  state_t            state_q, state_d;
  logic              load_en, start_en, done_d, done_q;
  logic              in_shift, last_bit, bit_end, sclk_phase;
  logic [DATA_W-1:0] shreg, din_aligned;
  logic [LEN_W-1:0]  len_q, len_c, bit_idx, shamt;

  assign len_c = LEN_W'(clamp_len(32'(bus.LEN), DATA_W));

  // MSB-first: move bit LEN-1 to the top so the line always takes shreg[DATA_W-1].
  assign shamt       = LEN_W'(DATA_W) - len_c;
  assign din_aligned = MSB_FIRST ? (bus.DIN << shamt) : bus.DIN;

  assign in_shift = (state_q == SHIFT);
  assign last_bit = (bit_idx == len_q - LEN_W'(1));

  piso_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start_en),
    .run        (in_shift),
    .div_in     (bus.DIV),
    .bit_end    (bit_end),
    .sclk_phase (sclk_phase)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    start_en = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.LOAD_VALID) begin
          load_en = 1'b1;
          state_d = LOADED;
        end
      end
      LOADED: begin
        // Load wins over a simultaneous start.
        if (bus.LOAD_VALID) begin
          load_en = 1'b1;
        end else if (bus.START_TX) begin
          start_en = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // Abort beats completion, so an abort on the last bit gives no TX_DONE.
        if (bus.ABORT) begin
          state_d = IDLE;
        end else if (bit_end && last_bit) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shreg   <= '0;
      len_q   <= '0;
      bit_idx <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      if (load_en) begin
        shreg <= din_aligned;
        len_q <= len_c;
      end
      if (start_en) begin
        bit_idx <= '0;
      end else if (in_shift && bit_end && !last_bit) begin
        bit_idx <= bit_idx + LEN_W'(1);
        shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      end
    end
  end

  assign bus.LOAD_READY = !in_shift;
  assign bus.TX_BUSY    = in_shift;
  assign bus.TX_DONE    = done_q;
  assign bus.SCLK       = in_shift && sclk_phase;
  assign bus.SOUT       = in_shift ? (MSB_FIRST ? shreg[DATA_W-1] : shreg[0]) : IDLE_LVL;
endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: two instances (32-bit LSB-first idle-low and
// 8-bit MSB-first idle-high) share stimulus and are compared every cycle
// against a frame-level reference model, plus directed scenarios.
module tb_piso_serial_tx;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  logic [31:0] din;
  logic [5:0]  len_a;
  logic [3:0]  len_b;
  logic [15:0] div;
  logic        load_valid, start_tx, abort;

  piso_serial_tx_if #(.DATA_W(32), .DIV_W(16)) bus_a();
  piso_serial_tx_if #(.DATA_W(8),  .DIV_W(16)) bus_b();

  assign bus_a.DIN = din;         assign bus_b.DIN = din[7:0];
  assign bus_a.LEN = len_a;       assign bus_b.LEN = len_b;
  assign bus_a.DIV = div;         assign bus_b.DIV = div;
  assign bus_a.LOAD_VALID = load_valid;  assign bus_b.LOAD_VALID = load_valid;
  assign bus_a.START_TX = start_tx;      assign bus_b.START_TX = start_tx;
  assign bus_a.ABORT = abort;            assign bus_b.ABORT = abort;

  piso_serial_tx #(.DATA_W(32), .DIV_W(16), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0))
    dut_a (.CLK(CLK), .RESET(RESET), .bus(bus_a));
  piso_serial_tx #(.DATA_W(8), .DIV_W(16), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1))
    dut_b (.CLK(CLK), .RESET(RESET), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of len bits, each held for div+1 cycles.
  int          m_dw[2]   = '{32, 8};
  bit          m_msb[2]  = '{1'b0, 1'b1};
  bit          m_idle[2] = '{1'b0, 1'b1};
  bit          m_loaded[2], m_shift[2], m_done[2];
  logic [31:0] m_word[2];
  int          m_len[2], m_div[2], m_t[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_loaded[d] = 0; m_shift[d] = 0; m_done[d] = 0;
      m_word[d] = '0; m_len[d] = 0; m_div[d] = 0; m_t[d] = 0;
    end
  endtask

  task automatic model_step();
    int lin;
    for (int d = 0; d < 2; d++) begin
      lin = (d == 0) ? int'(len_a) : int'(len_b);
      m_done[d] = 0;
      if (m_shift[d]) begin
        if (abort) begin
          m_shift[d] = 0; m_loaded[d] = 0;
        end else begin
          m_t[d]++;
          if (m_t[d] == m_len[d] * (m_div[d] + 1)) begin
            m_shift[d] = 0; m_loaded[d] = 0; m_done[d] = 1;
          end
        end
      end else if (load_valid) begin
        m_loaded[d] = 1;
        m_word[d]   = (d == 0) ? din : {24'b0, din[7:0]};
        m_len[d]    = (lin == 0 || lin > m_dw[d]) ? m_dw[d] : lin;
      end else if (start_tx && m_loaded[d]) begin
        m_shift[d] = 1; m_t[d] = 0; m_div[d] = int'(div);
      end
    end
  endtask

  function automatic bit exp_sout(input int d);
    int k, idx;
    if (!m_shift[d]) return m_idle[d];
    k   = m_t[d] / (m_div[d] + 1);
    idx = m_msb[d] ? (m_len[d] - 1 - k) : k;
    return m_word[d][idx];
  endfunction

  function automatic bit exp_sclk(input int d);
    if (!m_shift[d]) return 1'b0;
    return (m_t[d] % (m_div[d] + 1)) >= ((m_div[d] + 1) / 2);
  endfunction

  task automatic compare_all();
    check("a_sout",  32'(bus_a.SOUT),       32'(exp_sout(0)));
    check("a_sclk",  32'(bus_a.SCLK),       32'(exp_sclk(0)));
    check("a_busy",  32'(bus_a.TX_BUSY),    32'(m_shift[0]));
    check("a_ready", 32'(bus_a.LOAD_READY), 32'(!m_shift[0]));
    check("a_done",  32'(bus_a.TX_DONE),    32'(m_done[0]));
    check("b_sout",  32'(bus_b.SOUT),       32'(exp_sout(1)));
    check("b_sclk",  32'(bus_b.SCLK),       32'(exp_sclk(1)));
    check("b_busy",  32'(bus_b.TX_BUSY),    32'(m_shift[1]));
    check("b_ready", 32'(bus_b.LOAD_READY), 32'(!m_shift[1]));
    check("b_done",  32'(bus_b.TX_DONE),    32'(m_done[1]));
  endtask

  // Inputs are changed only between ticks (after the falling-edge compare).
  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic set_in(input logic lv, input logic st, input logic ab);
    load_valid = lv; start_tx = st; abort = ab;
  endtask

  task automatic quiesce();
    set_in(0, 0, 1); tick();
    set_in(0, 0, 0); tick();
  endtask

  int          k, n, done_cnt;
  logic [4:0]  seq;
  logic [31:0] word2, word3;

  initial begin
    din = '0; len_a = '0; len_b = '0; div = '0;
    set_in(0, 0, 0);
    model_reset();
    @(negedge CLK);
    compare_all();
    RESET = 1'b0;

    // Reset in the middle of bit 5 of a 32-bit frame.
    din = $urandom; len_a = 6'd0; len_b = 4'd0; div = 16'd1;
    set_in(1, 0, 0); tick();
    set_in(0, 1, 0); tick();
    set_in(0, 0, 0);
    for (int i = 0; i < 11; i++) tick();
    RESET = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("t1_rst_busy",  32'(bus_a.TX_BUSY), 32'd0);
    check("t1_rst_ready", 32'(bus_a.LOAD_READY), 32'd1);
    #1 RESET = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); done_cnt += int'(bus_a.TX_DONE); end
    check("t1_no_done", 32'(done_cnt), 32'd0);

    // Full 32-bit LSB-first frame, 4 cycles per bit.
    quiesce();
    din = 32'hA5A5_0F0F; len_a = 6'd0; len_b = 4'd0; div = 16'd3;
    set_in(1, 0, 0); tick();
    set_in(0, 1, 0); tick();
    set_in(0, 0, 0);
    k = 0; done_cnt = 0;
    while (k < 200) begin
      tick(); k++;
      if (bus_a.TX_DONE) begin done_cnt++; break; end
    end
    check("t2_done_latency", 32'(k), 32'd128);
    for (int i = 0; i < 4; i++) begin tick(); done_cnt += int'(bus_a.TX_DONE); end
    check("t2_done_once", 32'(done_cnt), 32'd1);

    // 8-bit MSB-first, LEN=5, one cycle per bit.
    quiesce();
    din = 32'h0000_00C3; len_a = 6'd3; len_b = 4'd5; div = 16'd0;
    set_in(1, 0, 0); tick();
    set_in(0, 1, 0); tick();
    set_in(0, 0, 0);
    seq = '0; n = 0; done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_b.TX_BUSY) begin seq = {seq[3:0], bus_b.SOUT}; n++; end
      if (bus_b.TX_DONE) begin done_cnt++; break; end
      tick();
    end
    check("t3_bit_count", 32'(n), 32'd5);
    check("t3_bits", 32'(seq), 32'h03);
    check("t3_done", 32'(done_cnt), 32'd1);

    // Load and start in the same cycle: the load wins.
    quiesce();
    len_a = 6'd0; len_b = 4'd0; div = 16'd0;
    din = $urandom; set_in(1, 0, 0); tick();
    word2 = $urandom; word2[0] = ~din[0];
    din = word2; set_in(1, 1, 0); tick();
    check("t4_no_shift", 32'(bus_a.TX_BUSY), 32'd0);
    set_in(0, 1, 0); tick();
    set_in(0, 0, 0);
    check("t4_shifting", 32'(bus_a.TX_BUSY), 32'd1);
    check("t4_first_bit", 32'(bus_a.SOUT), 32'(word2[0]));
    for (int i = 0; i < 40 && bus_a.TX_BUSY; i++) tick();

    // Abort at bit 10, then starts are ignored until reloaded.
    quiesce();
    din = $urandom; len_a = 6'd0; len_b = 4'd0; div = 16'd1;
    set_in(1, 0, 0); tick();
    set_in(0, 1, 0); tick();
    set_in(0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    set_in(0, 0, 1); tick();
    check("t5_abort_busy", 32'(bus_a.TX_BUSY), 32'd0);
    check("t5_abort_done", 32'(bus_a.TX_DONE), 32'd0);
    set_in(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_start_ignored", 32'(bus_a.TX_BUSY), 32'd0);
    end
    set_in(0, 0, 0);

    // Loads during a frame are refused; the next one is taken right after TX_DONE.
    quiesce();
    din = $urandom; len_a = 6'd0; len_b = 4'd0; div = 16'd1;
    set_in(1, 0, 0); tick();
    set_in(0, 1, 0); tick();
    set_in(1, 0, 0);
    k = 0;
    while (k < 200) begin
      din = $urandom; tick(); k++;
      if (bus_a.TX_DONE) break;
    end
    check("t6_done_seen", 32'(k), 32'd64);
    word3 = $urandom; din = word3; tick();
    set_in(0, 1, 0); tick();
    set_in(0, 0, 0);
    check("t6_reload_bit", 32'(bus_a.SOUT), 32'(word3[0]));
    quiesce();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      load_valid = ($urandom_range(0, 15) == 0);
      start_tx   = ($urandom_range(0, 5) == 0);
      abort      = ($urandom_range(0, 149) == 0);
      din        = $urandom;
      len_a      = 6'($urandom_range(0, 40));
      len_b      = 4'($urandom_range(0, 12));
      div        = 16'($urandom_range(0, 3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
